// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus bit-serial shifts, with
// valid/ready handshakes on both sides and a flush that kills in-flight work.
package sail_alu_pkg;
    localparam int kALU_OP_SEL_WIDTH     = 4;
    localparam int kALU_BRANCH_SEL_WIDTH = 3;

    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_ADD     = 4'd0;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SUB     = 4'd1;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_AND     = 4'd2;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_OR      = 4'd3;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_XOR     = 4'd4;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SLT     = 4'd5;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SLL     = 4'd6;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SRL     = 4'd7;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SRA     = 4'd8;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_BRANCH  = 4'd9;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_INVALID = 4'd15;

    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_BEQ  = 3'd0;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_BNE  = 3'd1;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_BLT  = 3'd2;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_BGE  = 3'd3;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_BLTU = 3'd4;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_BGEU = 3'd5;
endpackage

module alu_exec_unit
    import sail_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [kALU_OP_SEL_WIDTH-1:0]     op_sel_i,
    input  logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel_i,
    input  logic [DATA_WIDTH-1:0]            a_i,
    input  logic [DATA_WIDTH-1:0]            b_i,
    input  logic                             flush_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DATA_WIDTH-1:0]            result_o,
    output logic                             branch_enable_o,
    output logic                             busy_o
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        result_q, result_d;
    logic                         branch_q, branch_d;
    logic [DATA_WIDTH-1:0]        work_q, work_d;
    logic [SHAMT_W-1:0]           count_q, count_d;
    logic [kALU_OP_SEL_WIDTH-1:0] shift_op_q, shift_op_d;

    logic                  accept;
    logic                  is_shift;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_br;
    logic [DATA_WIDTH-1:0] shifted;

    assign ready_o         = (state_q == IDLE) || ((state_q == HOLD) && ready_i);
    assign accept          = valid_i && ready_o && !flush_i;
    assign valid_o         = (state_q == HOLD);
    assign busy_o          = (state_q == SHIFT);
    assign result_o        = result_q;
    assign branch_enable_o = branch_q;

    assign shamt    = b_i[SHAMT_W-1:0];
    assign is_shift = (op_sel_i == kSAIL_ALUCTL_SLL) || (op_sel_i == kSAIL_ALUCTL_SRL) ||
                      (op_sel_i == kSAIL_ALUCTL_SRA);

    always_comb begin : single_cycle_ops
        // NOTE: every combinational output is given a default first, so no path infers a latch.
        alu_res = '0;
        alu_br  = 1'b0;
        case (op_sel_i)
            kSAIL_ALUCTL_ADD: alu_res = a_i + b_i;
            kSAIL_ALUCTL_SUB: alu_res = a_i - b_i;
            kSAIL_ALUCTL_AND: alu_res = a_i & b_i;
            kSAIL_ALUCTL_OR:  alu_res = a_i | b_i;
            kSAIL_ALUCTL_XOR: alu_res = a_i ^ b_i;
            kSAIL_ALUCTL_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            kSAIL_ALUCTL_BRANCH: begin
                case (branch_sel_i)
                    kSAIL_ALUCTL_BEQ:  alu_br = (a_i == b_i);
                    kSAIL_ALUCTL_BNE:  alu_br = (a_i != b_i);
                    kSAIL_ALUCTL_BLT:  alu_br = ($signed(a_i) < $signed(b_i));
                    kSAIL_ALUCTL_BGE:  alu_br = ($signed(a_i) >= $signed(b_i));
                    kSAIL_ALUCTL_BLTU: alu_br = (a_i < b_i);
                    kSAIL_ALUCTL_BGEU: alu_br = (a_i >= b_i);
                    default:           alu_br = 1'b0;
                endcase
            end
            kSAIL_ALUCTL_INVALID: alu_res = '0;
            default:              alu_res = '0;
        endcase
    end

    // One-bit step of the latched shift; SRA replicates the sign bit.
    always_comb begin : shift_step
        shifted = work_q;
        case (shift_op_q)
            kSAIL_ALUCTL_SLL: shifted = {work_q[DATA_WIDTH-2:0], 1'b0};
            kSAIL_ALUCTL_SRL: shifted = {1'b0, work_q[DATA_WIDTH-1:1]};
            kSAIL_ALUCTL_SRA: shifted = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            default:          shifted = work_q;
        endcase
    end

    always_comb begin : next_state
        state_d    = state_q;
        result_d   = result_q;
        branch_d   = branch_q;
        work_d     = work_q;
        count_d    = count_q;
        shift_op_d = shift_op_q;

        if (flush_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (accept) begin
            if (!is_shift) begin
                state_d  = HOLD;
                result_d = alu_res;
                branch_d = alu_br;
            end else if (shamt == '0) begin
                state_d  = HOLD;
                result_d = a_i;
                branch_d = 1'b0;
            end else begin
                state_d    = SHIFT;
                work_d     = a_i;
                count_d    = shamt;
                shift_op_d = op_sel_i;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    work_d  = shifted;
                    count_d = count_q - 1'b1;
                    // The result register is only touched when the shift completes.
                    if (count_q == SHAMT_W'(1)) begin
                        state_d  = HOLD;
                        result_d = shifted;
                        branch_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            result_q   <= '0;
            branch_q   <= 1'b0;
            work_q     <= '0;
            count_q    <= '0;
            shift_op_q <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            branch_q   <= branch_d;
            work_q     <= work_d;
            count_q    <= count_d;
            shift_op_q <= shift_op_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level reference model compared
// every cycle, plus directed vectors with hand-computed results.
module tb_alu_exec_unit;
    import sail_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [3:0]  op_sel = '0;
    logic [2:0]  branch_sel = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready_o;
    logic        valid_o;
    logic        branch_en;
    logic        busy_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Reference model state: held result and cycles left until a pending shift lands.
    bit          m_valid  = 1'b0;
    bit          m_branch = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;
    int          m_left   = 0;

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .op_sel_i        (op_sel),
        .branch_sel_i    (branch_sel),
        .a_i             (a),
        .b_i             (b),
        .flush_i         (flush_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .result_o        (result_o),
        .branch_enable_o (branch_en),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit is_shift_op(input logic [3:0] op);
        return (op == kSAIL_ALUCTL_SLL) || (op == kSAIL_ALUCTL_SRL) || (op == kSAIL_ALUCTL_SRA);
    endfunction

    // Returns {branch, result} computed directly from the operation definitions.
    function automatic logic [32:0] ref_op(input logic [3:0] op, input logic [2:0] bs,
                                           input logic [31:0] x, input logic [31:0] y);
        int sh;
        bit br;
        sh = int'(y[4:0]);
        br = 1'b0;
        case (op)
            kSAIL_ALUCTL_ADD: return {1'b0, x + y};
            kSAIL_ALUCTL_SUB: return {1'b0, x - y};
            kSAIL_ALUCTL_AND: return {1'b0, x & y};
            kSAIL_ALUCTL_OR:  return {1'b0, x | y};
            kSAIL_ALUCTL_XOR: return {1'b0, x ^ y};
            kSAIL_ALUCTL_SLT: return {1'b0, ($signed(x) < $signed(y)) ? 32'd1 : 32'd0};
            kSAIL_ALUCTL_SLL: return {1'b0, x << sh};
            kSAIL_ALUCTL_SRL: return {1'b0, x >> sh};
            kSAIL_ALUCTL_SRA: return {1'b0, 32'($signed(x) >>> sh)};
            kSAIL_ALUCTL_BRANCH: begin
                case (bs)
                    kSAIL_ALUCTL_BEQ:  br = (x == y);
                    kSAIL_ALUCTL_BNE:  br = (x != y);
                    kSAIL_ALUCTL_BLT:  br = ($signed(x) < $signed(y));
                    kSAIL_ALUCTL_BGE:  br = ($signed(x) >= $signed(y));
                    kSAIL_ALUCTL_BLTU: br = (x < y);
                    kSAIL_ALUCTL_BGEU: br = (x >= y);
                    default:           br = 1'b0;
                endcase
                return {br, 32'd0};
            end
            default: return 33'd0;
        endcase
    endfunction

    initial begin : model
        logic [32:0] r;
        int          k;
        bit          rdy;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_valid  = 1'b0;
                m_branch = 1'b0;
                m_result = '0;
                m_left   = 0;
            end else begin
                rdy = (m_left == 0) && (!m_valid || ready_i);
                if (flush_i) begin
                    m_valid = 1'b0;
                    m_left  = 0;
                end else if (m_left != 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid  = 1'b1;
                        m_result = m_pend;
                        m_branch = 1'b0;
                    end
                end else if (valid_i && rdy) begin
                    r = ref_op(op_sel, branch_sel, a, b);
                    k = is_shift_op(op_sel) ? int'(b[4:0]) : 0;
                    if (k == 0) begin
                        m_valid  = 1'b1;
                        m_result = r[31:0];
                        m_branch = r[32];
                    end else begin
                        m_valid = 1'b0;
                        m_left  = k;
                        m_pend  = r[31:0];
                    end
                end else if (m_valid && ready_i) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin : compare
        bit exp_ready;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_ready = (m_left == 0) && (!m_valid || ready_i);
                check("cycle_ctrl", {valid_o, busy_o, ready_o}, {m_valid, m_left != 0, exp_ready});
                check("cycle_data", {branch_en, result_o}, {m_branch, m_result});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Issue one op from IDLE with ready_i=1 and check the completed result; returns at posedge+1.
    task automatic run_vec(input string name, input logic [3:0] op, input logic [2:0] bs,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] er, input logic eb);
        int k;
        k = is_shift_op(op) ? int'(y[4:0]) : 0;
        op_sel = op; branch_sel = bs; a = x; b = y; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        repeat (k) @(posedge clk);
        @(negedge clk);
        check(name, {valid_o, branch_en, result_o}, {1'b1, eb, er});
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        #1 reset_n = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", {valid_o, busy_o, ready_o, branch_en, result_o},
              {1'b0, 1'b0, 1'b1, 1'b0, 32'd0});
        @(posedge clk); #1 reset_n = 1'b1;

        // ADD, then the result drains with ready_i=1
        run_vec("add_5_7", kSAIL_ALUCTL_ADD, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0);
        @(negedge clk);
        check("add_valid_drop", {valid_o, ready_o}, 2'b01);
        @(posedge clk); #1;

        // SUB followed immediately by XOR
        op_sel = kSAIL_ALUCTL_SUB; a = 32'd3; b = 32'd5; valid_i = 1'b1;
        @(posedge clk); #1 op_sel = kSAIL_ALUCTL_XOR; a = 32'hF0F0_F0F0; b = 32'hFFFF_0000;
        @(negedge clk);
        check("b2b_sub", {valid_o, ready_o, result_o}, {1'b1, 1'b1, 32'hFFFF_FFFE});
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        check("b2b_xor", {valid_o, ready_o, result_o}, {1'b1, 1'b1, 32'h0F0F_F0F0});
        @(posedge clk); #1;

        // SRA by 4: four busy cycles, then the sign-extended result
        op_sel = kSAIL_ALUCTL_SRA; a = 32'h8000_0000; b = 32'd4; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sra_busy", {busy_o, ready_o, valid_o}, 3'b100);
        end
        @(negedge clk);
        check("sra_result", {valid_o, busy_o, result_o}, {1'b1, 1'b0, 32'hF800_0000});
        @(posedge clk); #1;

        // b=32 has shift amount 0: single-cycle passthrough
        run_vec("sll_by_0", kSAIL_ALUCTL_SLL, 3'd0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0);

        // Branch compares
        run_vec("blt_neg",  kSAIL_ALUCTL_BRANCH, kSAIL_ALUCTL_BLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        run_vec("bltu_neg", kSAIL_ALUCTL_BRANCH, kSAIL_ALUCTL_BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_vec("beq_9",    kSAIL_ALUCTL_BRANCH, kSAIL_ALUCTL_BEQ,  32'd9, 32'd9, 32'd0, 1'b1);
        run_vec("bne_9",    kSAIL_ALUCTL_BRANCH, kSAIL_ALUCTL_BNE,  32'd9, 32'd9, 32'd0, 1'b0);
        run_vec("bge_pos",  kSAIL_ALUCTL_BRANCH, kSAIL_ALUCTL_BGE,  32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        run_vec("bgeu_pos", kSAIL_ALUCTL_BRANCH, kSAIL_ALUCTL_BGEU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_vec("bsel_bad", kSAIL_ALUCTL_BRANCH, 3'd6, 32'd9, 32'd9, 32'd0, 1'b0);

        // Backpressure: result frozen while ready_i=0
        ready_i = 1'b0;
        op_sel = kSAIL_ALUCTL_OR; a = 32'h0000_0F00; b = 32'h0000_00F0; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {valid_o, ready_o, result_o}, {1'b1, 1'b0, 32'h0000_0FF0});
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        op_sel = kSAIL_ALUCTL_AND; a = 32'hFF00_FF00; b = 32'h0FF0_0FF0; valid_i = 1'b1;
        @(negedge clk);
        check("bp_release", {ready_o, valid_o, result_o}, {1'b1, 1'b1, 32'h0000_0FF0});
        @(posedge clk); #1 valid_i = 1'b0;
        @(negedge clk);
        check("bp_new_op", {valid_o, result_o}, {1'b1, 32'h0F00_0F00});
        @(posedge clk); #1;

        // Flush mid-shift with a competing valid_i
        op_sel = kSAIL_ALUCTL_SRL; a = 32'hDEAD_BEEF; b = 32'd20; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush_i = 1'b1; op_sel = kSAIL_ALUCTL_ADD; a = 32'd1; b = 32'd1; valid_i = 1'b1;
        @(negedge clk);
        check("flush_pre", {busy_o, valid_o}, 2'b10);
        @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("flush_idle", {valid_o, busy_o, ready_o, result_o}, {1'b0, 1'b0, 1'b1, 32'h0F00_0F00});
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("flush_no_late", {valid_o, busy_o, result_o}, {1'b0, 1'b0, 32'h0F00_0F00});
        @(posedge clk); #1;

        // Flush while holding a result: the new op must not be accepted
        op_sel = kSAIL_ALUCTL_ADD; a = 32'd2; b = 32'd3; valid_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b1; op_sel = kSAIL_ALUCTL_XOR; a = 32'd1; b = 32'd2;
        @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("flush_hold", {valid_o, ready_o, result_o}, {1'b0, 1'b1, 32'd5});
        @(posedge clk); #1;

        // Asynchronous reset mid-shift
        op_sel = kSAIL_ALUCTL_SRL; a = 32'hDEAD_BEEF; b = 32'd20; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("reset_async", {valid_o, busy_o, ready_o, branch_en, result_o},
                 {1'b0, 1'b0, 1'b1, 1'b0, 32'd0});
        @(posedge clk); #1 reset_n = 1'b1;

        // Remaining operations and boundaries
        run_vec("post_reset_add", kSAIL_ALUCTL_ADD, 3'd0, 32'd100, 32'd23, 32'd123, 1'b0);
        run_vec("add_wrap",  kSAIL_ALUCTL_ADD, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_vec("add_nobr",  kSAIL_ALUCTL_ADD, kSAIL_ALUCTL_BEQ, 32'd9, 32'd9, 32'd18, 1'b0);
        run_vec("slt_neg",   kSAIL_ALUCTL_SLT, 3'd0, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0);
        run_vec("slt_pos",   kSAIL_ALUCTL_SLT, 3'd0, 32'd1, 32'hFFFF_FFFE, 32'd0, 1'b0);
        run_vec("sll_31",    kSAIL_ALUCTL_SLL, 3'd0, 32'd1, 32'd31, 32'h8000_0000, 1'b0);
        run_vec("srl_1",     kSAIL_ALUCTL_SRL, 3'd0, 32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0);
        run_vec("srl_20",    kSAIL_ALUCTL_SRL, 3'd0, 32'hDEAD_BEEF, 32'd20, 32'h0000_0DEA, 1'b0);
        run_vec("sra_pos",   kSAIL_ALUCTL_SRA, 3'd0, 32'h7000_0000, 32'd2, 32'h1C00_0000, 1'b0);
        run_vec("invalid",   kSAIL_ALUCTL_INVALID, 3'd0, 32'd5, 32'd7, 32'd0, 1'b0);
        run_vec("unlisted",  4'd10, kSAIL_ALUCTL_BEQ, 32'd9, 32'd9, 32'd0, 1'b0);

        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
